// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU nametable VRAM path.
package ppu_pkg;

  typedef enum logic {
    MIR_VERT = 1'b0,
    MIR_HORZ = 1'b1
  } mir_e;

  localparam int          PPU_AW   = 14;
  localparam int          VRAM_AW  = 11;
  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

  typedef struct packed {
    logic              we;
    logic [PPU_AW-1:0] addr;
    logic [7:0]        wdata;
  } cpu_req_t;

endpackage

// File: rtl/ppu_vram_arbiter_if.sv
// Renderer, CPU data-port and VRAM signals of the nametable arbiter.
interface ppu_vram_arbiter_if;
  import ppu_pkg::*;

  logic               r_req;
  logic [PPU_AW-1:0]  r_addr;
  logic               r_gnt;
  logic               r_valid;
  logic [7:0]         r_data;

  logic               c_req;
  logic               c_we;
  logic [PPU_AW-1:0]  c_addr;
  logic [7:0]         c_wdata;
  logic               c_busy;
  logic               c_ack;
  logic               c_rvalid;
  logic [7:0]         c_rdata;
  logic               starve;

  logic [VRAM_AW-1:0] ram_addr;
  logic               ram_we;
  logic [7:0]         ram_wdata;
  logic [7:0]         ram_rdata;

  modport master (
    output r_req, r_addr, c_req, c_we, c_addr, c_wdata, ram_rdata,
    input  r_gnt, r_valid, r_data, c_busy, c_ack, c_rvalid, c_rdata, starve,
           ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  r_req, r_addr, c_req, c_we, c_addr, c_wdata, ram_rdata,
    output r_gnt, r_valid, r_data, c_busy, c_ack, c_rvalid, c_rdata, starve,
           ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/ppu_vram_map.sv
// Folds a 14-bit PPU address onto the 2 KB nametable RAM using cartridge mirroring.
// Purely combinational; in_range excludes pattern space and the palette page.
module ppu_vram_map
  import ppu_pkg::*;
(
  input  logic [PPU_AW-1:0]  addr,
  input  mir_e               mirror,
  output logic [VRAM_AW-1:0] ram_addr,
  output logic               in_range
);

  assign ram_addr = {(mirror == MIR_HORZ) ? addr[11] : addr[10], addr[9:0]};
  assign in_range = (addr[13] == NT_BASE[13]) && (addr[13:8] != PAL_BASE[13:8]);

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Arbitrates the single-port nametable VRAM between renderer reads and the CPU $2007 port.
// Renderer has priority; a CPU request blocked MAX_WAIT cycles is forced through.
module ppu_vram_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic                CLK25,
  input  logic                RESET_N,
  input  logic                MIRROR,
  ppu_vram_arbiter_if.slave   bus
);
  import ppu_pkg::*;

  cpu_req_t            cbuf;
  logic                c_pend;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                r_valid_q;
  logic                rd_pend;
  logic [7:0]          crdata_q;

  mir_e                mir;
  logic [VRAM_AW-1:0]  r_ram_addr;
  logic [VRAM_AW-1:0]  c_ram_addr;
  logic                c_in_range;
  logic                r_in_range_unused;

  logic                cpu_ir;
  logic                cpu_oor;
  logic                force_cpu;
  logic                r_go;
  logic                c_go;
  logic                c_ack;
  logic                oor_rd;
  logic [7:0]          c_rdata_nxt;

  assign mir = mir_e'(MIRROR);

  ppu_vram_map u_rmap (
    .addr     (bus.r_addr),
    .mirror   (mir),
    .ram_addr (r_ram_addr),
    .in_range (r_in_range_unused)
  );

  ppu_vram_map u_cmap (
    .addr     (cbuf.addr),
    .mirror   (mir),
    .ram_addr (c_ram_addr),
    .in_range (c_in_range)
  );

  // Out-of-range CPU requests never compete for the RAM, so they do not block the renderer.
  always_comb begin
    cpu_ir      = c_pend && c_in_range;
    cpu_oor     = c_pend && !c_in_range;
    force_cpu   = cpu_ir && (wait_cnt == WAIT_W'(MAX_WAIT));
    r_go        = RESET_N && bus.r_req && !force_cpu;
    c_go        = cpu_ir && (force_cpu || !bus.r_req);
    c_ack       = c_go || cpu_oor;
    oor_rd      = cpu_oor && !cbuf.we;
    c_rdata_nxt = crdata_q;
    if (rd_pend) begin
      c_rdata_nxt = bus.ram_rdata;
    end else if (oor_rd) begin
      c_rdata_nxt = 8'h00;
    end
  end

  assign bus.r_gnt     = r_go;
  assign bus.r_valid   = r_valid_q;
  assign bus.r_data    = r_valid_q ? bus.ram_rdata : 8'h00;
  assign bus.c_busy    = c_pend;
  assign bus.c_ack     = c_ack;
  assign bus.c_rvalid  = rd_pend || oor_rd;
  assign bus.c_rdata   = c_rdata_nxt;
  assign bus.starve    = force_cpu && bus.r_req;
  assign bus.ram_we    = c_go && cbuf.we;
  assign bus.ram_wdata = (c_go && cbuf.we) ? cbuf.wdata : 8'h00;
  assign bus.ram_addr  = r_go ? r_ram_addr : (c_go ? c_ram_addr : '0);

  always_ff @(posedge CLK25 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_valid_q <= 1'b0;
      rd_pend   <= 1'b0;
      crdata_q  <= 8'h00;
    end else begin
      r_valid_q <= r_go;
      rd_pend   <= c_go && !cbuf.we;
      crdata_q  <= c_rdata_nxt;
    end
  end

  // Capture is blocked for the whole pending window, including the ack cycle.
  always_ff @(posedge CLK25 or negedge RESET_N) begin
    if (!RESET_N) begin
      c_pend   <= 1'b0;
      cbuf     <= '0;
      wait_cnt <= '0;
    end else if (c_ack) begin
      c_pend   <= 1'b0;
      wait_cnt <= '0;
    end else if (c_pend) begin
      if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else if (bus.c_req) begin
      c_pend     <= 1'b1;
      cbuf.we    <= bus.c_we;
      cbuf.addr  <= bus.c_addr;
      cbuf.wdata <= bus.c_wdata;
      wait_cnt   <= '0;
    end
  end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed plus random bench for ppu_vram_arbiter against a cycle-level reference model.
module tb_ppu_vram_arbiter;
  import ppu_pkg::*;

  localparam int MAXW = 8;

  logic CLK25 = 1'b0;
  logic RESET_N;
  logic MIRROR;
  ppu_vram_arbiter_if bus();

  ppu_vram_arbiter #(.MAX_WAIT(MAXW), .WAIT_W(4)) dut (
    .CLK25   (CLK25),
    .RESET_N (RESET_N),
    .MIRROR  (MIRROR),
    .bus     (bus)
  );

  always #20 CLK25 = ~CLK25;

  bit [7:0] mem  [2048];
  bit [7:0] gold [2048];

  always @(posedge CLK25) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int errors = 0;
  int checks = 0;
  bit mir_sel;

  bit m_pend, m_we;
  int m_addr, m_wd, m_wait;
  bit m_rv_pend, m_cv_pend;
  int m_rv_data, m_cv_data, m_crdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mapa(input int a, input bit mir);
    int nt;
    nt = (a / 1024) % 4;
    return (mir ? nt / 2 : nt % 2) * 1024 + (a % 1024);
  endfunction

  function automatic bit inr(input int a);
    return (a >= 'h2000) && (a < 'h3F00);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_we = 0; m_addr = 0; m_wd = 0; m_wait = 0;
    m_rv_pend = 0; m_cv_pend = 0; m_rv_data = 0; m_cv_data = 0; m_crdata = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rgnt"},   bus.r_gnt,     0);
    chk({tag, "_rvalid"}, bus.r_valid,   0);
    chk({tag, "_rdata"},  bus.r_data,    0);
    chk({tag, "_cbusy"},  bus.c_busy,    0);
    chk({tag, "_cack"},   bus.c_ack,     0);
    chk({tag, "_crv"},    bus.c_rvalid,  0);
    chk({tag, "_crdata"}, bus.c_rdata,   0);
    chk({tag, "_starve"}, bus.starve,    0);
    chk({tag, "_raddr"},  bus.ram_addr,  0);
    chk({tag, "_rwe"},    bus.ram_we,    0);
    chk({tag, "_rwd"},    bus.ram_wdata, 0);
  endtask

  task automatic idle_inputs();
    bus.r_req = 0; bus.r_addr = '0; bus.c_req = 0; bus.c_we = 0;
    bus.c_addr = '0; bus.c_wdata = '0;
  endtask

  // One clock: drive at negedge, check the cycle's outputs, then advance the model.
  task automatic cycle(input bit rq, input int ra, input bit cq, input bit cwe,
                       input int ca, input int cd);
    bit e_rgnt, e_ack, e_starve, e_we, e_cv, cpu_go, served;
    int e_addr, e_wd, e_crd;
    @(negedge CLK25);
    MIRROR = mir_sel;
    bus.r_req = rq; bus.r_addr = 14'(ra); bus.c_req = cq; bus.c_we = cwe;
    bus.c_addr = 14'(ca); bus.c_wdata = 8'(cd);
    #1;
    e_rgnt = 0; e_ack = 0; e_starve = 0; e_we = 0; e_addr = 0; e_wd = 0;
    cpu_go = 0; served = 0;
    e_cv  = m_cv_pend;
    e_crd = m_cv_pend ? m_cv_data : m_crdata;
    if (m_pend && !inr(m_addr)) begin
      e_ack = 1; served = 1;
      if (!m_we) begin e_cv = 1; e_crd = 0; end
    end
    if (m_pend && inr(m_addr)) begin
      if (m_wait == MAXW) begin cpu_go = 1; e_starve = rq; end
      else if (!rq) cpu_go = 1;
    end
    if (!cpu_go && rq) begin e_rgnt = 1; e_addr = mapa(ra, mir_sel); end
    if (cpu_go) begin
      e_ack = 1; served = 1; e_addr = mapa(m_addr, mir_sel);
      if (m_we) begin e_we = 1; e_wd = m_wd; end
    end
    chk("r_gnt", bus.r_gnt, e_rgnt);
    chk("r_valid", bus.r_valid, m_rv_pend);
    if (m_rv_pend) chk("r_data", bus.r_data, m_rv_data);
    chk("c_busy", bus.c_busy, m_pend);
    chk("c_ack", bus.c_ack, e_ack);
    chk("c_rvalid", bus.c_rvalid, e_cv);
    chk("c_rdata", bus.c_rdata, e_crd);
    chk("starve", bus.starve, e_starve);
    chk("ram_we", bus.ram_we, e_we);
    chk("ram_addr", bus.ram_addr, e_addr);
    chk("ram_wdata", bus.ram_wdata, e_wd);
    m_rv_pend = e_rgnt;
    m_rv_data = gold[mapa(ra, mir_sel)];
    m_cv_pend = cpu_go && !m_we;
    m_cv_data = gold[mapa(m_addr, mir_sel)];
    m_crdata  = e_crd;
    if (cpu_go && m_we) gold[mapa(m_addr, mir_sel)] = 8'(m_wd);
    if (served) begin
      m_pend = 0; m_wait = 0;
    end else if (m_pend) begin
      m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
    end else if (cq) begin
      m_pend = 1; m_we = cwe; m_addr = ca; m_wd = cd; m_wait = 0;
    end
  endtask

  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ca, sel;
    mir_sel = 0;
    MIRROR  = 0;
    idle_inputs();
    RESET_N = 1'b1;
    #2;
    RESET_N = 1'b0;
    bus.r_req = 1; bus.r_addr = 14'h2345; bus.c_req = 1; bus.c_addr = 14'h2005;
    #1;
    chk_zero("rst");
    @(posedge CLK25);
    #1;
    chk_zero("rst_clk");
    idle_inputs();
    @(negedge CLK25);
    RESET_N = 1'b1;
    model_reset();

    // CPU write then read, vertical mirroring
    cycle(0, 0, 1, 1, 'h2005, 'hA5);
    nop();
    chk("wr_ack", bus.c_ack, 1);
    chk("wr_we", bus.ram_we, 1);
    chk("wr_addr", bus.ram_addr, 11'h005);
    cycle(0, 0, 1, 0, 'h2005, 0);
    nop();
    nop();
    chk("rd_rvalid", bus.c_rvalid, 1);
    chk("rd_data", bus.c_rdata, 8'hA5);

    // Horizontal mirroring
    mir_sel = 1;
    cycle(0, 0, 1, 1, 'h2C10, 'h3C);
    nop();
    chk("hm_addr", bus.ram_addr, 11'h410);
    cycle(0, 0, 1, 0, 'h2810, 0);
    nop();
    nop();
    chk("hm_rd", bus.c_rdata, 8'h3C);
    cycle(0, 0, 1, 0, 'h2410, 0);
    nop();
    nop();
    chk("hm_rd2", bus.c_rdata, 32'(gold['h010]));

    // Renderer priority and starvation guard
    cycle(1, 'h2000, 1, 1, 'h2100, 'h77);
    for (int k = 0; k < MAXW; k++) begin
      cycle(1, 'h2001 + k, 0, 0, 0, 0);
      chk("prio_rgnt", bus.r_gnt, 1);
    end
    cycle(1, 'h2040, 0, 0, 0, 0);
    chk("stv_starve", bus.starve, 1);
    chk("stv_ack", bus.c_ack, 1);
    chk("stv_rgnt", bus.r_gnt, 0);
    cycle(1, 'h2041, 0, 0, 0, 0);
    chk("stv_after", bus.r_gnt, 1);
    nop();

    // Out-of-range accesses
    cycle(0, 0, 1, 1, 'h3F00, 'h55);
    cycle(1, 'h2300, 0, 0, 0, 0);
    chk("oor_ack", bus.c_ack, 1);
    chk("oor_we", bus.ram_we, 0);
    nop();
    chk("oor_busy", bus.c_busy, 0);
    cycle(0, 0, 1, 0, 'h1234, 0);
    nop();
    chk("oor_rv", bus.c_rvalid, 1);
    chk("oor_rd", bus.c_rdata, 8'h00);

    // Second request while busy is ignored
    cycle(1, 'h2000, 1, 1, 'h2200, 'h11);
    cycle(1, 'h2001, 1, 1, 'h2200, 'h22);
    nop();
    chk("busy_wd", bus.ram_wdata, 8'h11);
    nop();
    chk("busy_noack", bus.c_ack, 0);
    cycle(0, 0, 1, 0, 'h2200, 0);
    nop();
    nop();
    chk("busy_rd", bus.c_rdata, 8'h11);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mir_sel = ~mir_sel;
      sel = $urandom_range(0, 7);
      if (sel == 0)      ca = $urandom_range(0, 'h3FFF);
      else if (sel == 1) ca = 'h3F00 + $urandom_range(0, 'hFF);
      else               ca = 'h2000 + $urandom_range(0, 'h1FFF);
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 'h3FFF),
            $urandom_range(0, 9) < 3, $urandom_range(0, 1), ca, $urandom_range(0, 255));
    end

    // Asynchronous reset with a pending request and r_req high
    cycle(1, 'h2010, 1, 1, 'h2222, 'h99);
    cycle(1, 'h2011, 0, 0, 0, 0);
    #4;
    RESET_N = 1'b0;
    #1;
    chk_zero("arst");
    idle_inputs();
    @(negedge CLK25);
    RESET_N = 1'b1;
    model_reset();
    nop();
    chk("arst_noack", bus.c_ack, 0);
    nop();
    nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
